// File: rtl/ymult_pkg.sv
// ymult_pkg: shared width default and FSM state type for ymult_seq (ACC state exists only with YMULT_ACC_EN).
package ymult_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd4
`ifdef YMULT_ACC_EN
    , ACC = 3'd3
`endif
  } state_e;
endpackage

// File: rtl/ymult_seq_if.sv
// ymult_seq_if: operand/result handshake bus between a producer/consumer (master) and ymult_seq (slave).
interface ymult_seq_if import ymult_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic signed [WIDTH-1:0]   a;
  logic signed [WIDTH-1:0]   b;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [2*WIDTH-1:0] z;
  logic                      out_valid;
  logic                      out_ready;
  logic                      acc_clr;
  logic                      ovf;
  modport slave (input a, b, in_valid, out_ready, acc_clr, output in_ready, z, out_valid, ovf);
  modport master (output a, b, in_valid, out_ready, acc_clr, input in_ready, z, out_valid, ovf);
endinterface

// File: rtl/ymult_seq_yadder.sv
// yadder: N-bit ripple-carry adder with carry in/out, the only adder of ymult_seq.
module yadder #(parameter int N = 32) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic         cin_i,
  output logic [N-1:0] s_o,
  output logic         cout_o
);
  logic [N:0] c;
  assign c[0] = cin_i;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s_o[i]   = x_i[i] ^ y_i[i] ^ c[i];
    assign c[i+1] = (x_i[i] & y_i[i]) | (c[i] & (x_i[i] ^ y_i[i]));
  end
  assign cout_o = c[N];
endmodule

// File: rtl/ymult_seq.sv
// ymult_seq: sequential signed shift-add multiplier, sign-magnitude core with final negation.
// Define YMULT_ACC_EN to add a 2*WIDTH-bit accumulator with sticky signed overflow.
module ymult_seq import ymult_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
  input logic        clk,
  input logic        rst_n,
  ymult_seq_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int P  = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  state_e         state_q, state_d;
  logic [W-1:0]   mc_q, mc_d, mp_q, mp_d, ax, bx;
  logic [P-1:0]   p_q, p_d, x, y, s;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sign_q, sign_d, cin, cout;
`ifdef YMULT_ACC_EN
  logic [P-1:0]   acc_q, acc_d, acc_in;
  logic           ovf_q, ovf_d, clr_q, clr_d, vflow;
  assign acc_in = clr_q ? '0 : acc_q;
  assign vflow  = (x[P-1] == y[P-1]) && (s[P-1] != x[P-1]);
`endif
  yadder #(.N(P)) u_add (.x_i(x), .y_i(y), .cin_i(cin), .s_o(s), .cout_o(cout));
  assign ax = bus.a[W-1] ? ~bus.a : bus.a;
  assign bx = bus.b[W-1] ? ~bus.b : bus.b;
  // In IDLE both magnitudes come out of one pass: the low half never carries into the high half.
  always_comb begin
    x   = '0;
    y   = '0;
    cin = 1'b0;
    case (state_q)
      IDLE: begin
        x   = {ax, bx};
        y   = {{(W-1){1'b0}}, bus.a[W-1], {W{1'b0}}};
        cin = bus.b[W-1];
      end
      CALC: begin
        x = {{W{1'b0}}, p_q[P-1:W]};
        y = {{W{1'b0}}, mp_q[0] ? mc_q : {W{1'b0}}};
      end
      FIX: begin
        x   = sign_q ? ~p_q : p_q;
        cin = sign_q;
      end
`ifdef YMULT_ACC_EN
      ACC: begin
        x = acc_in;
        y = p_q;
      end
`endif
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
`ifdef YMULT_ACC_EN
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    clr_d   = clr_q;
`endif
    case (state_q)
      IDLE: if (bus.in_valid) begin
        mc_d    = s[P-1:W];
        mp_d    = s[W-1:0];
        sign_d  = bus.a[W-1] ^ bus.b[W-1];
        p_d     = '0;
        cnt_d   = '0;
`ifdef YMULT_ACC_EN
        clr_d   = bus.acc_clr;
`endif
        state_d = CALC;
      end
      CALC: begin
        p_d     = {s[W:0], p_q[W-1:1]};
        mp_d    = {1'b0, mp_q[W-1:1]};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(W-1)) ? FIX : CALC;
      end
      FIX: begin
        p_d     = s;
`ifdef YMULT_ACC_EN
        state_d = ACC;
`else
        state_d = DONE;
`endif
      end
`ifdef YMULT_ACC_EN
      ACC: begin
        acc_d   = s;
        ovf_d   = (clr_q ? 1'b0 : ovf_q) | vflow;
        state_d = DONE;
      end
`endif
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mc_q    <= '0;
      mp_q    <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
`ifdef YMULT_ACC_EN
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      clr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
`ifdef YMULT_ACC_EN
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      clr_q   <= clr_d;
`endif
    end
  end
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
`ifdef YMULT_ACC_EN
  assign bus.z   = acc_q;
  assign bus.ovf = ovf_q;
  logic unused_ok;
  assign unused_ok = cout;
`else
  assign bus.z   = p_q;
  assign bus.ovf = 1'b0;
  logic unused_ok;
  assign unused_ok = cout ^ bus.acc_clr;
`endif
endmodule
